// File: rtl/adc_readout_pkg.sv
// Package: adc_readout_pkg
// Shared definitions for the PSD ADC readout controller:
//   - sequencer state encoding
//   - FIFO word layout {tag[4:0], sel[2:0], data[15:0]}
//   - shift-register channel indices (chip0 a,b,c,t = 0..3, chip1 a,b,c,t = 4..7)
//   - channel-stepping and word-packing helpers
package adc_readout_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SHIFT = 3'd2,
      SEL   = 3'd3,
      PUSH  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int FIFO_W   = 24;
   localparam int DATA_W   = 16;
   localparam int SEL_W    = 3;
   localparam int TAG_W    = 5;
   localparam int DATA_LSB = 0;
   localparam int SEL_LSB  = DATA_LSB + DATA_W;
   localparam int TAG_LSB  = SEL_LSB + SEL_W;

   localparam logic [2:0] CH0_A = 3'd0;
   localparam logic [2:0] CH0_B = 3'd1;
   localparam logic [2:0] CH0_C = 3'd2;
   localparam logic [2:0] CH0_T = 3'd3;
   localparam logic [2:0] CH1_A = 3'd4;
   localparam logic [2:0] CH1_B = 3'd5;
   localparam logic [2:0] CH1_C = 3'd6;
   localparam logic [2:0] CH1_T = 3'd7;

   // First channel of a frame: chip0 block if chip0 is enabled, otherwise chip1 block.
   function automatic logic [2:0] first_channel(input logic [1:0] en);
      first_channel = en[0] ? CH0_A : CH1_A;
   endfunction

   // Last channel: chip1 t-channel, or chip0 t-channel when chip1 is not enabled.
   function automatic logic is_last_channel(input logic [2:0] ch, input logic [1:0] en);
      is_last_channel = (ch == CH1_T) || ((ch == CH0_T) && !en[1]);
   endfunction

   // Assemble one FIFO word from event tag, channel index and shift-register data.
   function automatic logic [FIFO_W-1:0] pack_word(input logic [TAG_W-1:0]  tag,
                                                   input logic [SEL_W-1:0]  sel,
                                                   input logic [DATA_W-1:0] data);
      pack_word = {tag, sel, data};
   endfunction

endpackage

// File: rtl/adc_readout_ctrl_sclk_burst_gen.sv
// Module: sclk_burst_gen
// Generates one burst of NUM_BITS serial-clock periods on the enabled ADC
// clock lines. Each bit is SCLK_DIV cycles low followed by SCLK_DIV cycles
// high; disabled lines and the idle state are held high.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   go         in   start a burst (sclk goes low on the next clock edge)
//   en[1:0]    in   per-chip clock enable, captured with go
//   adc_sclk   out  registered serial clocks, idle high
//   burst_done out  high during the final cycle of the last high phase
import adc_readout_pkg::*;

module sclk_burst_gen #(
   parameter int SCLK_DIV = 2,
   parameter int NUM_BITS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [1:0] en,
   output logic [1:0] adc_sclk,
   output logic       burst_done
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam logic [4:0]       BIT_LAST = 5'(NUM_BITS - 1);

   logic             active;
   logic             high_phase;
   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       bit_cnt;
   logic [1:0]       en_l;

   // Combinational so the sequencer leaves SHIFT exactly when the last high phase ends.
   assign burst_done = active && high_phase && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

   // Half-period divider, bit counter and registered clock outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active     <= 1'b0;
         high_phase <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= 5'd0;
         en_l       <= 2'b00;
         adc_sclk   <= 2'b11;
      end else if (go) begin
         active     <= 1'b1;
         high_phase <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= 5'd0;
         en_l       <= en;
         adc_sclk   <= ~en;
      end else if (active) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!high_phase) begin
               high_phase <= 1'b1;
               adc_sclk   <= 2'b11;
            end else if (bit_cnt == BIT_LAST) begin
               active     <= 1'b0;
               high_phase <= 1'b0;
               adc_sclk   <= 2'b11;
            end else begin
               bit_cnt    <= bit_cnt + 5'd1;
               high_phase <= 1'b0;
               adc_sclk   <= ~en_l;
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end else begin
         adc_sclk <= 2'b11;
      end
   end

endmodule

// File: rtl/adc_readout_ctrl.sv
// Module: adc_readout_ctrl
// Readout sequencer for the PSD ADC shift-register bank. On an accepted
// start it clears the shift registers, bursts the serial clocks to the
// enabled chips, then steps adc_mux_sel over every enabled channel and
// writes one tagged 24-bit word per channel into the event FIFO.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   start          1-cycle frame request, ignored while busy
//   chip_en[1:0]   chip enables, sampled with an accepted start
//   adc_sclk[1:0]  serial clocks to chip 0/1, idle high
//   adc_reg_reset  shift-register clear pulse
//   adc_mux_sel    shift-register select (0-3 chip0, 4-7 chip1)
//   adc_reg        selected shift-register contents
//   fifo_din       {evt_cnt, adc_mux_sel, adc_reg}
//   fifo_wr_en     1-cycle FIFO write strobe
//   fifo_full      FIFO full, blocks writes
//   busy, done     frame in progress / 1-cycle end-of-frame pulse
import adc_readout_pkg::*;

module adc_readout_ctrl #(
   parameter int SCLK_DIV = 2,
   parameter int NUM_BITS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        chip_en,
   output logic [1:0]        adc_sclk,
   output logic              adc_reg_reset,
   output logic [2:0]        adc_mux_sel,
   input  logic [15:0]       adc_reg,
   output logic [FIFO_W-1:0] fifo_din,
   output logic              fifo_wr_en,
   input  logic              fifo_full,
   output logic              busy,
   output logic              done
);

   state_t     state;
   logic [1:0] en;
   logic [2:0] ch;
   logic [4:0] evt_cnt;
   logic       wrote;
   logic       burst_go;
   logic       burst_done;

   // The burst starts on the edge that leaves CLR, so sclk is low in the first SHIFT cycle.
   assign burst_go = (state == CLR);

   sclk_burst_gen #(
      .SCLK_DIV (SCLK_DIV),
      .NUM_BITS (NUM_BITS)
   ) u_burst (
      .clk        (clk),
      .reset      (reset),
      .go         (burst_go),
      .en         (en),
      .adc_sclk   (adc_sclk),
      .burst_done (burst_done)
   );

   // Frame sequencer: state, channel stepper, event counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         en            <= 2'b00;
         ch            <= 3'd0;
         evt_cnt       <= 5'd0;
         wrote         <= 1'b0;
         adc_reg_reset <= 1'b1;
         adc_mux_sel   <= 3'd0;
         fifo_din      <= '0;
         fifo_wr_en    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         adc_reg_reset <= 1'b0;
         fifo_wr_en    <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  wrote <= 1'b0;
                  if (chip_en != 2'b00) begin
                     en            <= chip_en;
                     ch            <= first_channel(chip_en);
                     busy          <= 1'b1;
                     adc_reg_reset <= 1'b1;
                     state         <= CLR;
                  end else begin
                     // Nothing enabled: report an empty frame without touching the ADCs.
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CLR: begin
               state <= SHIFT;
            end
            SHIFT: begin
               if (burst_done) begin
                  state <= SEL;
               end else begin
                  state <= SHIFT;
               end
            end
            SEL: begin
               // adc_reg settles for a full cycle before PUSH captures it.
               adc_mux_sel <= ch;
               state       <= PUSH;
            end
            PUSH: begin
               if (fifo_full) begin
                  state <= PUSH;
               end else begin
                  fifo_din   <= pack_word(evt_cnt, adc_mux_sel, adc_reg);
                  fifo_wr_en <= 1'b1;
                  wrote      <= 1'b1;
                  if (is_last_channel(ch, en)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     ch    <= ch + 3'd1;
                     state <= SEL;
                  end
               end
            end
            DONE: begin
               if (wrote) begin
                  evt_cnt <= evt_cnt + 5'd1;
               end else begin
                  evt_cnt <= evt_cnt;
               end
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Testbench for adc_readout_ctrl with a behavioural shift-register bank.
module tb_adc_readout_ctrl;
   import adc_readout_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  chip_en;
   logic [1:0]  adc_sclk;
   logic        adc_reg_reset;
   logic [2:0]  adc_mux_sel;
   logic [15:0] adc_reg;
   logic [23:0] fifo_din;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   adc_readout_ctrl #(.SCLK_DIV(2), .NUM_BITS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .chip_en(chip_en),
      .adc_sclk(adc_sclk), .adc_reg_reset(adc_reg_reset), .adc_mux_sel(adc_mux_sel),
      .adc_reg(adc_reg), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .busy(busy), .done(done)
   );

   // Shift-register bank model and activity monitor
   logic [15:0] bank [8] = '{8{16'h0000}};
   logic [15:0] pat  [8] = '{8{16'hA5C3}};
   logic [3:0]  fall_idx [2] = '{4'd0, 4'd0};
   logic [1:0]  prev_sclk = 2'b11;
   int          falls [2] = '{0, 0};
   int          lows  [2] = '{0, 0};
   int          done_cnt  = 0;
   int          full_viol = 0;
   int          widx      = 0;
   logic [23:0] wmem [1024];

   assign adc_reg = bank[adc_mux_sel];

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wmem[widx % 1024] <= fifo_din;
         widx <= widx + 1;
         if (fifo_full) full_viol <= full_viol + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_sclk <= adc_sclk;
      for (int c = 0; c < 2; c++) begin
         if (prev_sclk[c] && !adc_sclk[c]) falls[c] <= falls[c] + 1;
         if (!adc_sclk[c]) lows[c] <= lows[c] + 1;
      end
      if (adc_reg_reset) begin
         for (int k = 0; k < 8; k++) bank[k] <= 16'h0000;
         fall_idx[0] <= 4'd0;
         fall_idx[1] <= 4'd0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (prev_sclk[c] && !adc_sclk[c]) begin
               fall_idx[c] <= fall_idx[c] + 4'd1;
               for (int r = 0; r < 4; r++)
                  bank[c*4+r] <= {bank[c*4+r][14:0], pat[c*4+r][4'd15 - fall_idx[c]]};
            end
         end
      end
   end

   int         checks   = 0;
   int         failures = 0;
   logic [4:0] exp_evt  = 5'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] en;
      int uniq;         // 1: distinct pattern per channel
      int stall_push;   // PUSH index at which fifo_full rises
      int stall_len;    // cycles of fifo_full (0 = none)
      int extra_start;  // cycle of a second start pulse (0 = none)
      int exp_words;
      int exp_first;
      int exp_lat;
      int exp_falls0;
      int exp_falls1;
   } vec_t;

   vec_t vecs [6];

   task automatic run_frame(input vec_t v);
      int w0, d0, fv0, cnt;
      int f0 [2];
      int l0 [2];
      logic got;
      logic [23:0] exp_w;
      for (int k = 0; k < 8; k++)
         pat[k] = (v.uniq != 0) ? (16'hA5C3 ^ (16'(k) * 16'h1111)) : 16'hA5C3;
      w0 = widx; d0 = done_cnt; fv0 = full_viol;
      f0[0] = falls[0]; f0[1] = falls[1]; l0[0] = lows[0]; l0[1] = lows[1];
      chip_en = v.en;
      start = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 400) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         start = (cnt == v.extra_start);
         if (v.stall_len > 0 && cnt == 67 + 2*v.stall_push) fifo_full = 1'b1;
         if (cnt == 67 + 2*v.stall_push + v.stall_len) fifo_full = 1'b0;
         if (cnt == 1) begin
            chk("busy_after_start", 64'(busy), 64'(v.en != 2'b00));
            chk("reg_reset_clr", 64'(adc_reg_reset), 64'(v.en != 2'b00));
         end
         if (cnt == 2 && v.en != 2'b00) chk("reg_reset_drop", 64'(adc_reg_reset), 64'(0));
         if (done) begin
            got = 1'b1;
            chk("busy_at_done", 64'(busy), 64'(0));
         end
      end
      start = 1'b0;
      fifo_full = 1'b0;
      chk("done_seen", 64'(got), 64'(1));
      chk("latency", 64'(cnt), 64'(v.exp_lat));
      repeat (3) @(negedge clk);
      chk("done_count", 64'(done_cnt - d0), 64'(1));
      chk("word_count", 64'(widx - w0), 64'(v.exp_words));
      chk("sclk0_falls", 64'(falls[0] - f0[0]), 64'(v.exp_falls0));
      chk("sclk1_falls", 64'(falls[1] - f0[1]), 64'(v.exp_falls1));
      chk("sclk0_low_cycles", 64'(lows[0] - l0[0]), 64'(2 * v.exp_falls0));
      chk("sclk1_low_cycles", 64'(lows[1] - l0[1]), 64'(2 * v.exp_falls1));
      chk("wr_while_full", 64'(full_viol - fv0), 64'(0));
      for (int i = 0; i < v.exp_words && i < widx - w0; i++) begin
         exp_w = {exp_evt, 3'(v.exp_first + i), pat[v.exp_first + i]};
         chk("fifo_word", 64'(wmem[(w0 + i) % 1024]), 64'(exp_w));
      end
      if (v.exp_words > 0) exp_evt = exp_evt + 5'd1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'b11, 0, 0, 0,  0, 8, 0, 82, 16, 16};
      vecs[1] = '{2'b10, 1, 0, 0,  0, 4, 4, 74,  0, 16};
      vecs[2] = '{2'b11, 1, 2, 10, 0, 8, 0, 92, 16, 16};
      vecs[3] = '{2'b11, 1, 0, 0, 30, 8, 0, 82, 16, 16};
      vecs[4] = '{2'b01, 1, 0, 0,  0, 4, 0, 74, 16,  0};
      vecs[5] = '{2'b00, 1, 0, 0,  0, 0, 0,  1,  0,  0};

      reset = 1'b1; start = 1'b0; chip_en = 2'b00; fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sclk", 64'(adc_sclk), 64'(2'b11));
      chk("rst_reg_reset", 64'(adc_reg_reset), 64'(1));
      chk("rst_mux_sel", 64'(adc_mux_sel), 64'(0));
      chk("rst_fifo_din", 64'(fifo_din), 64'(0));
      chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("reg_reset_release", 64'(adc_reg_reset), 64'(0));
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i]);
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of SHIFT abandons the frame
      begin
         int w0;
         chip_en = 2'b11;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (20) @(negedge clk);
         w0 = widx;
         reset = 1'b1;
         #1;
         chk("midrst_sclk", 64'(adc_sclk), 64'(2'b11));
         chk("midrst_wr_en", 64'(fifo_wr_en), 64'(0));
         chk("midrst_busy", 64'(busy), 64'(0));
         chk("midrst_reg_reset", 64'(adc_reg_reset), 64'(1));
         repeat (3) @(negedge clk);
         chk("midrst_reg_reset_hold", 64'(adc_reg_reset), 64'(1));
         reset = 1'b0;
         repeat (2) @(negedge clk);
         chk("midrst_no_writes", 64'(widx - w0), 64'(0));
         chk("midrst_idle_busy", 64'(busy), 64'(0));
         exp_evt = 5'd0;
      end
      run_frame(vecs[0]);
      repeat (2) @(negedge clk);

      // 32 frames: tag field runs 1..31 then wraps to 0
      for (int f = 0; f < 32; f++) begin
         run_frame(vecs[4]);
         @(negedge clk);
      end
      // Empty frame leaves the counter alone; the next frame shows it
      run_frame(vecs[5]);
      @(negedge clk);
      run_frame(vecs[4]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
